// File: rtl/rc_dp_pkg.sv
`default_nettype none
// ============================================================================
// Module : rc_dp_pkg
// Desc   : Opcodes, operand-source codes, memory FSM states and config-word
//          field positions shared by rc_datapath_hs (RC_DP_ADDR_PTR_EN aware).
// Rev    : 1.0 - initial release
// ============================================================================
package rc_dp_pkg;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_XOR  = 5'd5,
    OP_SLL  = 5'd6,
    OP_SRL  = 5'd7,
    OP_SRA  = 5'd8,
    OP_BEQ  = 5'd9,
    OP_BNE  = 5'd10,
    OP_LWD  = 5'd11,
    OP_LWI  = 5'd12,
    OP_SWD  = 5'd13,
    OP_SWI  = 5'd14,
    OP_EXIT = 5'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_e;

  localparam int c_SRC_ZERO   = 0;
  localparam int c_SRC_RES    = 1;
  localparam int c_SRC_LEFT   = 2;
  localparam int c_SRC_RIGHT  = 3;
  localparam int c_SRC_TOP    = 4;
  localparam int c_SRC_BOTTOM = 5;
  localparam int c_SRC_REG0   = 6;
  localparam int c_SRC_IMM    = 14;
  localparam int c_NUM_SRC    = 16;

  localparam int c_A_SEL_MSB   = 31;
  localparam int c_A_SEL_LSB   = 28;
  localparam int c_B_SEL_MSB   = 27;
  localparam int c_B_SEL_LSB   = 24;
  localparam int c_OP_MSB      = 23;
  localparam int c_OP_LSB      = 19;
  localparam int c_REG_WE_BIT  = 18;
  localparam int c_REG_SEL_MSB = 17;
  localparam int c_REG_SEL_LSB = 15;

endpackage : rc_dp_pkg
`default_nettype wire

// File: rtl/rc_dp_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : rc_dp_mem_ctrl
// Desc   : req/gnt/rvalid memory FSM with latched address/data/control and
//          completion strobes; RC_DP_ADDR_PTR_EN adds the address pointer.
// Rev    : 1.0 - initial release
// ============================================================================
module rc_dp_mem_ctrl
  import rc_dp_pkg::*;
#(
  parameter int DP_WIDTH    = 32,
  parameter int CONST_WIDTH = 13
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   i_start,
  input  logic                   i_store,
  input  logic                   i_direct,
  input  logic [DP_WIDTH-1:0]    i_addr,
  input  logic [DP_WIDTH-1:0]    i_wdata,
  input  logic [CONST_WIDTH-1:0] i_imm,
  input  logic                   i_gnt,
  input  logic                   i_rvalid,
  output logic                   o_idle,
  output logic                   o_stall,
  output logic                   o_req,
  output logic                   o_wen,
  output logic                   o_ind,
  output logic [DP_WIDTH-1:0]    o_add,
  output logic [DP_WIDTH-1:0]    o_wdata,
  output logic [CONST_WIDTH-1:0] o_add_inc,
  output logic                   o_load_done,
  output logic                   o_store_done
);

  mem_state_e                 r_state, w_next;
  logic                       r_store, r_direct;
  logic [DP_WIDTH-1:0]        r_addr, r_wdata, w_start_addr;
  logic [CONST_WIDTH-1:0]     r_imm;

`ifdef RC_DP_ADDR_PTR_EN
  logic [DP_WIDTH-1:0] r_ptr;
  logic [DP_WIDTH-1:0] w_imm_sext;
  assign w_imm_sext   = {{(DP_WIDTH-CONST_WIDTH){r_imm[CONST_WIDTH-1]}}, r_imm};
  assign w_start_addr = i_direct ? r_ptr : i_addr;
  assign o_add_inc    = '0;
`else
  assign w_start_addr = i_addr;
  assign o_add_inc    = (o_req && r_direct) ? r_imm : '0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_load_done  = 1'b0;
    o_store_done = 1'b0;
    case (r_state)
      ST_IDLE: if (i_start) w_next = ST_REQ;
      ST_REQ: begin
        if (i_gnt) begin
          // a load whose data arrives with the grant completes without WAIT
          if (r_store) begin
            o_store_done = 1'b1;
            w_next       = ST_IDLE;
          end else if (i_rvalid) begin
            o_load_done = 1'b1;
            w_next      = ST_IDLE;
          end else begin
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (i_rvalid) begin
          o_load_done = 1'b1;
          w_next      = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_store  <= 1'b0;
      r_direct <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_imm    <= '0;
`ifdef RC_DP_ADDR_PTR_EN
      r_ptr    <= '0;
`endif
    end else begin
      if (i_start) begin
        r_store  <= i_store;
        r_direct <= i_direct;
        r_addr   <= w_start_addr;
        r_wdata  <= i_wdata;
        r_imm    <= i_imm;
      end
`ifdef RC_DP_ADDR_PTR_EN
      // for direct ops r_addr already holds the pointer, so one update covers both
      if (o_load_done || o_store_done) r_ptr <= r_addr + w_imm_sext;
`endif
    end
  end

  assign o_idle  = (r_state == ST_IDLE);
  assign o_stall = !o_idle;
  assign o_req   = (r_state == ST_REQ);
  assign o_wen   = !(o_req && r_store);
  assign o_ind   = o_req && !r_direct;
  assign o_add   = o_req ? r_addr : '0;
  assign o_wdata = (o_req && r_store) ? r_wdata : '0;

endmodule : rc_dp_mem_ctrl
`default_nettype wire

// File: rtl/rc_datapath_hs.sv
`default_nettype none
// ============================================================================
// Module : rc_datapath_hs
// Desc   : CGRA reconfigurable-cell datapath: config decode, operand muxes,
//          ALU/branch/exit and handshaked memory port (RC_DP_ADDR_PTR_EN).
// Rev    : 1.0 - initial release
// ============================================================================
module rc_datapath_hs
  import rc_dp_pkg::*;
#(
  parameter int DP_WIDTH    = 32,
  parameter int NUM_REG     = 4,
  parameter int CONST_WIDTH = 13,
  parameter int BR_ADD_W    = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   conf_valid_i,
  output logic                   conf_ready_o,
  input  logic [31:0]            conf_rdata_i,
  input  logic [DP_WIDTH-1:0]    left_res_i,
  input  logic [DP_WIDTH-1:0]    right_res_i,
  input  logic [DP_WIDTH-1:0]    top_res_i,
  input  logic [DP_WIDTH-1:0]    bottom_res_i,
  output logic [DP_WIDTH-1:0]    result_o,
  output logic [1:0]             flag_o,
  output logic                   br_req_o,
  output logic [BR_ADD_W-1:0]    br_add_o,
  output logic                   exec_end_o,
  output logic                   data_req_o,
  input  logic                   data_gnt_i,
  output logic                   data_wen_o,
  output logic                   data_ind_o,
  output logic [DP_WIDTH-1:0]    data_add_o,
  output logic [DP_WIDTH-1:0]    data_wdata_o,
  input  logic                   data_rvalid_i,
  input  logic [DP_WIDTH-1:0]    data_rdata_i,
  output logic [CONST_WIDTH-1:0] add_inc_o,
  output logic                   dp_stall_o
);

  localparam int c_SHW = $clog2(DP_WIDTH);

  logic [3:0]             w_a_sel, w_b_sel;
  logic [4:0]             w_op;
  logic                   w_reg_we;
  logic [2:0]             w_reg_sel;
  logic [CONST_WIDTH-1:0] w_imm;
  logic [DP_WIDTH-1:0]    w_imm_sext, w_a, w_b, w_alu;
  logic [DP_WIDTH-1:0]    w_src [c_NUM_SRC];
  logic                   w_is_alu, w_is_mem, w_taken, w_accept, w_mem_start;
  logic                   w_idle, w_load_done, w_store_done;

  logic [DP_WIDTH-1:0]    r_result;
  logic [1:0]             r_flag;
  logic                   r_br_req, r_exit, r_mem_we;
  logic [BR_ADD_W-1:0]    r_br_add;
  logic [2:0]             r_mem_sel;
  logic [DP_WIDTH-1:0]    r_regs [NUM_REG];

  assign w_a_sel    = conf_rdata_i[c_A_SEL_MSB:c_A_SEL_LSB];
  assign w_b_sel    = conf_rdata_i[c_B_SEL_MSB:c_B_SEL_LSB];
  assign w_op       = conf_rdata_i[c_OP_MSB:c_OP_LSB];
  assign w_reg_we   = conf_rdata_i[c_REG_WE_BIT];
  assign w_reg_sel  = conf_rdata_i[c_REG_SEL_MSB:c_REG_SEL_LSB];
  assign w_imm      = conf_rdata_i[CONST_WIDTH-1:0];
  assign w_imm_sext = {{(DP_WIDTH-CONST_WIDTH){w_imm[CONST_WIDTH-1]}}, w_imm};

  generate
    if (CONST_WIDTH < c_REG_SEL_LSB) begin : g_spare_bits
      logic w_unused_spare;
      assign w_unused_spare = ^conf_rdata_i[c_REG_SEL_LSB-1:CONST_WIDTH];
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < c_NUM_SRC; i++) w_src[i] = '0;
    w_src[c_SRC_RES]    = r_result;
    w_src[c_SRC_LEFT]   = left_res_i;
    w_src[c_SRC_RIGHT]  = right_res_i;
    w_src[c_SRC_TOP]    = top_res_i;
    w_src[c_SRC_BOTTOM] = bottom_res_i;
    for (int i = 0; i < NUM_REG; i++) w_src[c_SRC_REG0+i] = r_regs[i];
    w_src[c_SRC_IMM]    = w_imm_sext;
  end

  assign w_a = w_src[w_a_sel];
  assign w_b = w_src[w_b_sel];

  always_comb begin
    w_alu    = '0;
    w_is_alu = 1'b1;
    case (w_op)
      OP_ADD:  w_alu = w_a + w_b;
      OP_SUB:  w_alu = w_a - w_b;
      OP_AND:  w_alu = w_a & w_b;
      OP_OR:   w_alu = w_a | w_b;
      OP_XOR:  w_alu = w_a ^ w_b;
      OP_SLL:  w_alu = w_a << w_b[c_SHW-1:0];
      OP_SRL:  w_alu = w_a >> w_b[c_SHW-1:0];
      OP_SRA:  w_alu = $signed(w_a) >>> w_b[c_SHW-1:0];
      default: w_is_alu = 1'b0;
    endcase
  end

  assign w_is_mem    = (w_op == OP_LWD) || (w_op == OP_LWI) || (w_op == OP_SWD) || (w_op == OP_SWI);
  assign w_taken     = ((w_op == OP_BEQ) && (w_a == w_b)) || ((w_op == OP_BNE) && (w_a != w_b));
  assign w_accept    = conf_valid_i && w_idle;
  assign w_mem_start = w_accept && w_is_mem;

  rc_dp_mem_ctrl #(
    .DP_WIDTH    (DP_WIDTH),
    .CONST_WIDTH (CONST_WIDTH)
  ) u_mem_ctrl (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_start      (w_mem_start),
    .i_store      ((w_op == OP_SWD) || (w_op == OP_SWI)),
    .i_direct     ((w_op == OP_LWD) || (w_op == OP_SWD)),
    .i_addr       (w_b),
    .i_wdata      (w_a),
    .i_imm        (w_imm),
    .i_gnt        (data_gnt_i),
    .i_rvalid     (data_rvalid_i),
    .o_idle       (w_idle),
    .o_stall      (dp_stall_o),
    .o_req        (data_req_o),
    .o_wen        (data_wen_o),
    .o_ind        (data_ind_o),
    .o_add        (data_add_o),
    .o_wdata      (data_wdata_o),
    .o_add_inc    (add_inc_o),
    .o_load_done  (w_load_done),
    .o_store_done (w_store_done)
  );

  // accept happens only in IDLE and completions only outside it, so the
  // ALU and memory write paths below never collide
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_result  <= '0;
      r_flag    <= '0;
      r_br_req  <= 1'b0;
      r_br_add  <= '0;
      r_exit    <= 1'b0;
      r_mem_we  <= 1'b0;
      r_mem_sel <= '0;
      for (int i = 0; i < NUM_REG; i++) r_regs[i] <= '0;
    end else begin
      r_br_req <= w_accept && w_taken;
      r_br_add <= (w_accept && w_taken) ? w_imm[BR_ADD_W-1:0] : '0;
      r_exit   <= w_accept && (w_op == OP_EXIT);
      if (w_accept && w_is_alu) begin
        r_result <= w_alu;
        r_flag   <= {w_alu[DP_WIDTH-1], ~|w_alu};
      end
      if (w_mem_start) begin
        r_mem_we  <= w_reg_we;
        r_mem_sel <= w_reg_sel;
      end
      if (w_load_done)  r_result <= data_rdata_i;
      if (w_store_done) r_result <= data_wdata_o;
      for (int i = 0; i < NUM_REG; i++) begin
        if (w_accept && w_is_alu && w_reg_we && (w_reg_sel == 3'(i))) r_regs[i] <= w_alu;
        if (w_load_done && r_mem_we && (r_mem_sel == 3'(i)))          r_regs[i] <= data_rdata_i;
      end
    end
  end

  assign conf_ready_o = w_idle;
  assign result_o     = r_result;
  assign flag_o       = r_flag;
  assign br_req_o     = r_br_req;
  assign br_add_o     = r_br_add;
  assign exec_end_o   = r_exit;

endmodule : rc_datapath_hs
`default_nettype wire

// File: tb/tb_rc_datapath_hs.sv
`default_nettype none
// ============================================================================
// Module : tb_rc_datapath_hs
// Desc   : Self-checking bench for rc_datapath_hs (optionally RC_DP_ADDR_PTR_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rc_datapath_hs;
  import rc_dp_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        conf_valid_i = 1'b0;
  logic        conf_ready_o;
  logic [31:0] conf_rdata_i = '0;
  logic [31:0] left_res_i = '0, right_res_i = '0, top_res_i = '0, bottom_res_i = '0;
  logic [31:0] result_o;
  logic [1:0]  flag_o;
  logic        br_req_o;
  logic [3:0]  br_add_o;
  logic        exec_end_o;
  logic        data_req_o;
  logic        data_gnt_i = 1'b0;
  logic        data_wen_o, data_ind_o;
  logic [31:0] data_add_o, data_wdata_o;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic [12:0] add_inc_o;
  logic        dp_stall_o;

  rc_datapath_hs #(.DP_WIDTH(32), .NUM_REG(4), .CONST_WIDTH(13), .BR_ADD_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .conf_valid_i(conf_valid_i), .conf_ready_o(conf_ready_o),
    .conf_rdata_i(conf_rdata_i), .left_res_i(left_res_i), .right_res_i(right_res_i),
    .top_res_i(top_res_i), .bottom_res_i(bottom_res_i), .result_o(result_o), .flag_o(flag_o),
    .br_req_o(br_req_o), .br_add_o(br_add_o), .exec_end_o(exec_end_o), .data_req_o(data_req_o),
    .data_gnt_i(data_gnt_i), .data_wen_o(data_wen_o), .data_ind_o(data_ind_o),
    .data_add_o(data_add_o), .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .add_inc_o(add_inc_o), .dp_stall_o(dp_stall_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cw(input logic [3:0] a, input logic [3:0] b, input logic [4:0] op,
                                     input logic we, input logic [2:0] sel, input logic [12:0] imm);
    return {a, b, op, we, sel, 2'b00, imm};
  endfunction

  // present one config word for a single accept, then return at the next falling edge
  task automatic issue(input logic [31:0] w);
    conf_valid_i = 1'b1;
    conf_rdata_i = w;
    @(negedge clk_i);
    conf_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0; conf_valid_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [4:0]  op;
    logic        we;
    logic [2:0]  sel;
    logic [12:0] imm;
    logic [31:0] left;
    logic [31:0] res;
    logic [1:0]  flag;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] a, input logic [3:0] b, input logic [4:0] op,
                              input logic we, input logic [2:0] sel, input logic [12:0] imm,
                              input logic [31:0] left, input logic [31:0] res, input logic [1:0] flag);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.we = we; v.sel = sel; v.imm = imm;
    v.left = left; v.res = res; v.flag = flag;
    return v;
  endfunction

  // reference model state
  logic [31:0] m_res;
  logic [1:0]  m_flag;
  logic [31:0] m_regs [4];

  function automatic logic [31:0] m_src(input int s, input logic [31:0] imm_sext);
    if (s == 1) return m_res;
    if (s == 2) return left_res_i;
    if (s == 3) return right_res_i;
    if (s == 4) return top_res_i;
    if (s == 5) return bottom_res_i;
    if (s >= 6 && s <= 9) return m_regs[s-6];
    if (s == 14) return imm_sext;
    return 32'h0;
  endfunction

  vec_t tbl [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    // ---------------- reset state ----------------
    right_res_i = 32'h20; top_res_i = 32'h30; bottom_res_i = 32'h40;
    @(negedge clk_i); @(negedge clk_i);
    chk("rst_hold", 64'({result_o, flag_o, data_req_o, data_wen_o, conf_ready_o, dp_stall_o, br_req_o, exec_end_o}),
        64'({32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_release", 64'({result_o, flag_o, data_req_o, data_wen_o, conf_ready_o, dp_stall_o, data_add_o}),
        64'({32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0}) << 32);

    // ---------------- ALU vector table ----------------
    tbl[0]  = mk(14, 2, OP_ADD, 1, 2, 13'd5,     32'd7,        32'd12,       2'b00);
    tbl[1]  = mk(0,  0, OP_NOP, 0, 0, 13'd0,     32'd0,        32'd12,       2'b00);
    tbl[2]  = mk(8,  2, OP_SUB, 0, 0, 13'd0,     32'd12,       32'd0,        2'b01);
    tbl[3]  = mk(0,  2, OP_SUB, 1, 0, 13'd0,     32'd1,        32'hFFFFFFFF, 2'b10);
    tbl[4]  = mk(6,  2, OP_AND, 0, 0, 13'd0,     32'h0F0F,     32'h0F0F,     2'b00);
    tbl[5]  = mk(1, 14, OP_OR,  0, 0, 13'h0F0,   32'd0,        32'h0FFF,     2'b00);
    tbl[6]  = mk(1, 14, OP_XOR, 0, 0, 13'h0FFF,  32'd0,        32'h0,        2'b01);
    tbl[7]  = mk(14, 2, OP_SLL, 0, 0, 13'd1,     32'd35,       32'd8,        2'b00);
    tbl[8]  = mk(6,  2, OP_SRL, 0, 0, 13'd0,     32'd4,        32'h0FFFFFFF, 2'b00);
    tbl[9]  = mk(6,  2, OP_SRA, 0, 0, 13'd0,     32'd31,       32'hFFFFFFFF, 2'b10);
    tbl[10] = mk(14, 0, OP_ADD, 1, 3, 13'h1FFF,  32'd0,        32'hFFFFFFFF, 2'b10);
    tbl[11] = mk(14,14, 5'd20,  1, 1, 13'd3,     32'd0,        32'hFFFFFFFF, 2'b10);
    tbl[12] = mk(9, 14, OP_ADD, 0, 0, 13'd1,     32'd0,        32'h0,        2'b01);
    tbl[13] = mk(3,  5, OP_ADD, 0, 0, 13'd0,     32'd0,        32'h60,       2'b00);
    tbl[14] = mk(4,  8, OP_ADD, 0, 0, 13'd0,     32'd0,        32'h3C,       2'b00);
    tbl[15] = mk(15, 2, OP_ADD, 0, 0, 13'd0,     32'd5,        32'd5,        2'b00);
    for (int i = 0; i < 16; i++) begin
      left_res_i = tbl[i].left;
      issue(cw(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].we, tbl[i].sel, tbl[i].imm));
      chk($sformatf("tbl%0d", i), 64'({result_o, flag_o}), 64'({tbl[i].res, tbl[i].flag}));
    end

    // ---------------- branch / exit ----------------
    left_res_i = 32'd9;
    issue(cw(14, 2, OP_BEQ, 0, 0, 13'd9));
    chk("beq_taken", 64'({br_req_o, br_add_o, result_o, flag_o}), 64'({1'b1, 4'd9, 32'd5, 2'b00}));
    @(negedge clk_i);
    chk("beq_pulse_end", 64'({br_req_o, br_add_o}), 64'h0);
    issue(cw(14, 2, OP_BNE, 0, 0, 13'd9));
    chk("bne_equal", 64'({br_req_o, br_add_o}), 64'h0);
    left_res_i = 32'd3;
    issue(cw(14, 2, OP_BNE, 0, 0, 13'd9));
    chk("bne_taken", 64'({br_req_o, br_add_o}), 64'({1'b1, 4'd9}));
    issue(cw(0, 0, OP_EXIT, 0, 0, 13'd0));
    chk("exit_pulse", 64'({exec_end_o, br_req_o}), 64'({1'b1, 1'b0}));
    @(negedge clk_i);
    chk("exit_end", 64'(exec_end_o), 64'(1'b0));

    // ---------------- randomized against the model ----------------
    do_reset();
    m_res = '0; m_flag = '0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    for (int k = 0; k < 300; k++) begin
      int unsigned kind;
      logic [4:0]  op;
      logic [3:0]  as, bs;
      logic [12:0] im;
      logic        we, taken, is_alu;
      logic [2:0]  rs;
      logic [31:0] a, b, r, sx;
      logic [40:0] exp;
      kind = $urandom_range(0, 14);
      if (kind <= 8)       op = 5'(kind);
      else if (kind == 9)  op = OP_BEQ;
      else if (kind == 10) op = OP_BNE;
      else if (kind == 11) op = OP_EXIT;
      else                 op = 5'($urandom_range(16, 31));
      as = 4'($urandom_range(0, 15));
      bs = ($urandom_range(0, 1) == 1) ? as : 4'($urandom_range(0, 15));
      im = 13'($urandom);
      we = 1'($urandom);
      rs = 3'($urandom);
      left_res_i = $urandom; right_res_i = $urandom; top_res_i = $urandom; bottom_res_i = $urandom;
      sx = {{19{im[12]}}, im};
      a = m_src(int'(as), sx);
      b = m_src(int'(bs), sx);
      is_alu = 1'b1;
      r = '0;
      case (op)
        OP_ADD:  r = a + b;
        OP_SUB:  r = a - b;
        OP_AND:  r = a & b;
        OP_OR:   r = a | b;
        OP_XOR:  r = a ^ b;
        OP_SLL:  r = a << b[4:0];
        OP_SRL:  r = a >> b[4:0];
        OP_SRA:  r = $signed(a) >>> b[4:0];
        default: is_alu = 1'b0;
      endcase
      if (is_alu) begin
        m_res  = r;
        m_flag = {r[31], r == 32'h0};
        if (we && rs < 3'd4) m_regs[rs[1:0]] = r;
      end
      taken = ((op == OP_BEQ) && (a == b)) || ((op == OP_BNE) && (a != b));
      exp = {m_res, m_flag, taken, taken ? im[3:0] : 4'h0, op == OP_EXIT, 1'b0};
      conf_valid_i = 1'b1;
      conf_rdata_i = cw(as, bs, op, we, rs, im);
      @(negedge clk_i);
      chk($sformatf("rand%0d", k), 64'({result_o, flag_o, br_req_o, br_add_o, exec_end_o, dp_stall_o}), 64'(exp));
    end
    conf_valid_i = 1'b0;

    // ---------------- memory: LWI with delayed gnt and rvalid ----------------
    do_reset();
    issue(cw(0, 14, OP_LWI, 1, 1, 13'h100));
    chk("lwi_req", 64'({data_req_o, data_add_o, data_wen_o, data_ind_o, dp_stall_o, conf_ready_o}),
        64'({1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0}));
    @(negedge clk_i);
    chk("lwi_req_hold", 64'({data_req_o, data_add_o}), 64'({1'b1, 32'h100}));
    data_gnt_i = 1'b1;
    @(negedge clk_i);
    data_gnt_i = 1'b0;
    chk("lwi_wait", 64'({data_req_o, dp_stall_o, conf_ready_o}), 64'({1'b0, 1'b1, 1'b0}));
    @(negedge clk_i); @(negedge clk_i);
    chk("lwi_wait_stall", 64'({dp_stall_o, result_o}), 64'({1'b1, 32'h0}));
    data_rvalid_i = 1'b1; data_rdata_i = 32'hDEAD;
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    chk("lwi_done", 64'({result_o, flag_o, dp_stall_o, conf_ready_o}), 64'({32'hDEAD, 2'b00, 1'b0, 1'b1}));
    issue(cw(7, 0, OP_ADD, 0, 0, 13'd0));
    chk("lwi_r1", 64'(result_o), 64'(32'hDEAD));

    // ---------------- memory: stores ----------------
    left_res_i = 32'h55;
`ifdef RC_DP_ADDR_PTR_EN
    right_res_i = 32'h1FC;
    issue(cw(2, 3, OP_SWI, 0, 0, 13'd4));
    chk("swi_req", 64'({data_add_o, data_ind_o, data_wen_o}), 64'({32'h1FC, 1'b1, 1'b0}));
    data_gnt_i = 1'b1; @(negedge clk_i); data_gnt_i = 1'b0;
    issue(cw(2, 3, OP_SWD, 0, 0, 13'd4));
    chk("swd_ptr0", 64'({data_req_o, data_add_o, data_wen_o, add_inc_o}), 64'({1'b1, 32'h200, 1'b0, 13'd0}));
    data_gnt_i = 1'b1; @(negedge clk_i); data_gnt_i = 1'b0;
    issue(cw(2, 3, OP_SWD, 0, 0, 13'd4));
    chk("swd_ptr1", 64'({data_req_o, data_add_o, data_wen_o}), 64'({1'b1, 32'h204, 1'b0}));
    data_gnt_i = 1'b1; @(negedge clk_i); data_gnt_i = 1'b0;
    chk("swd_done", 64'({result_o, data_req_o, data_wen_o}), 64'({32'h55, 1'b0, 1'b1}));
`else
    right_res_i = 32'h300;
    issue(cw(2, 3, OP_SWD, 0, 0, 13'd4));
    chk("swd_req", 64'({data_req_o, data_add_o, data_wdata_o[15:0], data_wen_o, data_ind_o, add_inc_o}),
        64'({1'b1, 32'h300, 16'h55, 1'b0, 1'b0, 13'd4}));
    data_gnt_i = 1'b1; @(negedge clk_i); data_gnt_i = 1'b0;
    chk("swd_done", 64'({result_o, data_req_o, data_wen_o, add_inc_o, dp_stall_o}),
        64'({32'h55, 1'b0, 1'b1, 13'd0, 1'b0}));
`endif

    // ---------------- memory: gnt and rvalid together, then stray rvalid ----------------
    right_res_i = 32'h40;
    issue(cw(0, 3, OP_LWD, 1, 0, 13'd0));
`ifndef RC_DP_ADDR_PTR_EN
    chk("lwd_addr", 64'({data_req_o, data_add_o, data_ind_o}), 64'({1'b1, 32'h40, 1'b0}));
`endif
    data_gnt_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'h1234;
    @(negedge clk_i);
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    chk("lwd_direct_done", 64'({result_o, dp_stall_o, conf_ready_o}), 64'({32'h1234, 1'b0, 1'b1}));
    issue(cw(6, 0, OP_ADD, 0, 0, 13'd0));
    chk("lwd_r0", 64'(result_o), 64'(32'h1234));
    data_rvalid_i = 1'b1; data_rdata_i = 32'h0BAD;
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    chk("rvalid_idle_ignored", 64'({result_o, dp_stall_o}), 64'({32'h1234, 1'b0}));

    // ---------------- async reset in REQ and in WAIT ----------------
    issue(cw(0, 14, OP_LWI, 1, 1, 13'h100));
    chk("rst_req_pre", 64'(data_req_o), 64'(1'b1));
    #2 rst_i = 1'b0;
    #1 chk("rst_req_drop", 64'({data_req_o, conf_ready_o, dp_stall_o}), 64'({1'b0, 1'b1, 1'b0}));
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    issue(cw(0, 14, OP_LWI, 1, 1, 13'h100));
    data_gnt_i = 1'b1; @(negedge clk_i); data_gnt_i = 1'b0;
    chk("rst_wait_pre", 64'({data_req_o, dp_stall_o}), 64'({1'b0, 1'b1}));
    #2 rst_i = 1'b0;
    #1 chk("rst_wait_idle", 64'({data_req_o, conf_ready_o, dp_stall_o, result_o}), 64'({1'b0, 1'b1, 1'b0, 32'h0}));
    @(negedge clk_i);
    rst_i = 1'b1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hBEEF;
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    chk("late_rvalid_res", 64'(result_o), 64'(32'h0));
    issue(cw(7, 0, OP_ADD, 0, 0, 13'd0));
    chk("late_rvalid_r1", 64'(result_o), 64'(32'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rc_datapath_hs
`default_nettype wire
